// File: rtl/video_timing_gen_pkg.sv
// video_timing_pkg: shared state type, 480p default raster timing and the
// total-length helper used by the timing generator and its interface.
`default_nettype none

package video_timing_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } vt_state_t;

  localparam int DEF_H_ACTIVE = 720;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 62;
  localparam int DEF_H_BP     = 60;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 9;
  localparam int DEF_V_SYNC   = 6;
  localparam int DEF_V_BP     = 30;

  function automatic int total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

`default_nettype wire

// File: rtl/video_timing_gen_if.sv
// video_timing_gen_if: control inputs and raster outputs of the timing generator.
`default_nettype none

interface video_timing_gen_if
  import video_timing_pkg::*;
#(
  parameter int HW = $clog2(total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP)),
  parameter int VW = $clog2(total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP))
);

  logic          ena;
  logic          run;
  logic          busy;
  logic          de;
  logic          line_start;
  logic          frame_start;
  logic          hs_str;
  logic          vs_str;
  logic [HW-1:0] x;
  logic [VW-1:0] y;
  logic [7:0]    frame_cnt;

  modport master (
    input  ena, run,
    output busy, de, line_start, frame_start, hs_str, vs_str, x, y, frame_cnt
  );

  modport slave (
    output ena, run,
    input  busy, de, line_start, frame_start, hs_str, vs_str, x, y, frame_cnt
  );

endinterface

`default_nettype wire

// File: rtl/video_timing_gen_wrap_counter.sv
// wrap_counter: counts 0..MAX on inc_i, wraps to 0; wrap_o flags the wrapping increment.
`default_nettype none

module wrap_counter #(
  parameter int MAX = 7,
  parameter int W   = $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear_i,
  input  logic         inc_i,
  output logic [W-1:0] count_o,
  output logic         wrap_o
);

  localparam logic [W-1:0] TOP = W'(MAX);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  assign wrap_o  = inc_i && (count_q == TOP);
  assign count_o = count_q;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (inc_i) begin
      count_d = wrap_o ? '0 : count_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/video_timing_gen.sv
// video_timing_gen: pixel/line raster counter with registered single-pixel strobes,
// active-video flag and frame counter, advancing only on ena edges.
`default_nettype none

module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic                clk,
  input  logic                rst,
  video_timing_gen_if.master  vt
);

  localparam int H_TOTAL = total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] X_DE_END = HW'(H_ACTIVE);
  localparam logic [HW-1:0] X_HS     = HW'(H_ACTIVE + H_FP);
  localparam logic [VW-1:0] Y_DE_END = VW'(V_ACTIVE);
  localparam logic [VW-1:0] Y_VS     = VW'(V_ACTIVE + V_FP);

  vt_state_t state_q, state_d;

  logic [HW-1:0] x_cnt, x_nxt;
  logic [VW-1:0] y_cnt, y_nxt;
  logic          x_wrap, y_wrap;
  logic          x_inc, cnt_clear;

  logic busy_q, busy_d;
  logic de_q, de_d;
  logic ls_q, ls_d;
  logic fs_q, fs_d;
  logic hs_q, hs_d;
  logic vs_q, vs_d;
  logic [7:0] frame_cnt_q;

  // Counters sit at 0 in IDLE so a start always lands on (0,0).
  assign cnt_clear = (state_q == IDLE);
  assign x_inc     = vt.ena && (state_q == RUN);

  wrap_counter #(.MAX(H_TOTAL - 1), .W(HW)) u_x_cnt (
    .clk     (clk),
    .rst     (rst),
    .clear_i (cnt_clear),
    .inc_i   (x_inc),
    .count_o (x_cnt),
    .wrap_o  (x_wrap)
  );

  wrap_counter #(.MAX(V_TOTAL - 1), .W(VW)) u_y_cnt (
    .clk     (clk),
    .rst     (rst),
    .clear_i (cnt_clear),
    .inc_i   (x_wrap),
    .count_o (y_cnt),
    .wrap_o  (y_wrap)
  );

  // Next-state and flag decode; only consumed on ena edges.
  always_comb begin
    state_d = state_q;
    x_nxt   = '0;
    y_nxt   = '0;
    busy_d  = 1'b0;
    de_d    = 1'b0;
    ls_d    = 1'b0;
    fs_d    = 1'b0;
    hs_d    = 1'b0;
    vs_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (vt.run) state_d = RUN;
      end
      RUN: begin
        x_nxt = x_wrap ? '0 : x_cnt + HW'(1);
        y_nxt = y_wrap ? '0 : (x_wrap ? y_cnt + VW'(1) : y_cnt);
        if (y_wrap && !vt.run) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (state_d == RUN) begin
      busy_d = 1'b1;
      de_d   = (x_nxt < X_DE_END) && (y_nxt < Y_DE_END);
      ls_d   = (x_nxt == '0);
      fs_d   = (x_nxt == '0) && (y_nxt == '0);
      hs_d   = (x_nxt == X_HS);
      vs_d   = (x_nxt == '0) && (y_nxt == Y_VS);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      de_q    <= 1'b0;
      ls_q    <= 1'b0;
      fs_q    <= 1'b0;
      hs_q    <= 1'b0;
      vs_q    <= 1'b0;
    end else if (vt.ena) begin
      state_q <= state_d;
      busy_q  <= busy_d;
      de_q    <= de_d;
      ls_q    <= ls_d;
      fs_q    <= fs_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt_q <= 8'd0;
    end else if (y_wrap) begin
      frame_cnt_q <= frame_cnt_q + 8'd1;
    end
  end

  assign vt.busy        = busy_q;
  assign vt.de          = de_q;
  assign vt.line_start  = ls_q;
  assign vt.frame_start = fs_q;
  assign vt.hs_str      = hs_q;
  assign vt.vs_str      = vs_q;
  assign vt.x           = x_cnt;
  assign vt.y           = y_cnt;
  assign vt.frame_cnt   = frame_cnt_q;

endmodule

`default_nettype wire

// File: doc/video_timing_gen.md
# video_timing_gen

Raster timing generator for the ADV7393 output path. It counts pixels and lines on a pixel-rate clock enable and emits registered single-pixel strobes: line start, frame start, hsync start and vsync start. It also emits the active-video flag and the raster coordinates. It sits directly upstream of the sync pulse stretchers, which widen `hs_str` and `vs_str` into sync pulses, and of the pixel fetch logic, which consumes `de`, `x` and `y`.

## Interface
- `H_ACTIVE`, 720: active pixels per line
- `H_FP`, 16: horizontal front porch, in pixels
- `H_SYNC`, 62: hsync width, in pixels; informational for the downstream stretcher
- `H_BP`, 60: horizontal back porch, in pixels
- `V_ACTIVE`, 480: active lines per frame
- `V_FP`, 9: vertical front porch, in lines
- `V_SYNC`, 6: vsync width, in lines
- `V_BP`, 30: vertical back porch, in lines
- `clk`  in  1  clock (already decided)
- `rst`  in  1  reset; asynchronous, active-high (already decided)
- `ena`  in  1  pixel-rate clock enable
- `run`  in  1  run request; acted on only at a frame boundary
- `busy`  out  1  high while state is RUN
- `de`  out  1  active video
- `line_start`  out  1  strobe at x=0
- `frame_start`  out  1  strobe at x=0, y=0
- `hs_str`  out  1  strobe at hsync start
- `vs_str`  out  1  strobe at vsync start
- `x`  out  HW  pixel index; HW=$clog2(H_TOTAL)
- `y`  out  VW  line index; VW=$clog2(V_TOTAL)
- `frame_cnt`  out  8  count of completed frames; wraps

## Operation
- Derived constants: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
- FSM has two states, IDLE and RUN. Reset value is IDLE.
- The state machine and all outputs update only on clk edges where `ena`=1. Each strobe is therefore held from one ena edge to the next (one pixel period). A downstream stage that samples `str && ena` sees exactly one qualifying cycle.
- IDLE:
  - `x`, `y` and every flag/strobe are 0; `frame_cnt` keeps its value.
  - On an ena edge with `run`=1: go to RUN and load x=0, y=0.
- RUN, on each ena edge:
  - x increments.
  - When x=H_TOTAL-1: x wraps to 0 and y increments.
  - When y=V_TOTAL-1 as well (last pixel of the frame): y wraps to 0 and `frame_cnt` increments modulo 256.
  - At that last-pixel edge, `run` is sampled. If `run`=1, continue at (0,0). If `run`=0, go to IDLE.
- `run` deasserted mid-frame has no effect until the frame ends. Frames are never truncated.
- Registered outputs are decoded from the next (x,y):
  - `de` = x<H_ACTIVE && y<V_ACTIVE
  - `line_start` = x==0
  - `frame_start` = x==0 && y==0
  - `hs_str` = x==H_ACTIVE+H_FP
  - `vs_str` = x==0 && y==V_ACTIVE+V_FP
- `busy` = state==RUN.

## Timing
- Reset (asynchronous): state IDLE; `x`, `y`, `frame_cnt` = 0; all 1-bit outputs = 0.
- Start latency: the first ena edge that sees `run`=1 in IDLE produces `frame_start`=`line_start`=`de`=1 and `busy`=1 after that same edge.
- Strobe periods:
  - `line_start` and `hs_str`: H_TOTAL ena edges.
  - `frame_start` and `vs_str`: H_TOTAL·V_TOTAL ena edges.
- Stop: the ena edge after (H_TOTAL-1, V_TOTAL-1) with `run`=0 clears all outputs and `busy`. `frame_cnt` already holds the incremented value.
- `ena`=0: everything freezes, with no change on any output.
- `rst` asserted mid-line: immediate return to reset values. A restart always begins at (0,0).

## Structure
- Package `video_timing_pkg`:
  - state enum `vt_state_t` {IDLE, RUN}
  - 480p default timing constants
  - the H_TOTAL/V_TOTAL derivation function
- Sub-module `wrap_counter` (parameter MAX):
  - inputs: clear, inc
  - outputs: count, wrap
  - instantiated once for x and once for y; the y instance is incremented by the x wrap.

## Test plan
Directed scenarios use small parameters: H=4/1/2/1 (H_TOTAL=8) and V=3/1/1/1 (V_TOTAL=6).
- Reset check: `rst` pulse → all outputs 0, `busy`=0, `frame_cnt`=0.
- Continuous start: `ena`=1, `run`=1 → `frame_start` on the 1st edge; `hs_str` at x=5 every 8 clk; `de` high for x 0–3 on y 0–2; `vs_str` 32 clk after `frame_start`.
- Sparse enable: `ena` high 1 clk in 3 → each strobe lasts 3 clk with exactly one `ena`-coincident cycle; one line spans 24 clk.
- Stop mid-frame: drop `run` at (2,1) → frame completes; `busy` falls 1 ena edge after (7,5); `frame_cnt`=1.
- Counter wrap: `run` held for 256 frames → `frame_cnt` wraps 255→0; `frame_start` is continuous with no gap.
- Async reset at (3,2) mid-frame → outputs cleared without waiting for clk; with `run`=1, restart at (0,0).
